// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Purpose:
//   LED pattern engine for a WIDTH-bit LED bank. A prescaler produces a step
//   tick every P = max(DIV >> speed, 1) enabled clock cycles. On each step the
//   pattern rotates left, rotates right, bounces between the ends, or holds,
//   depending on the selected mode. A synchronous load replaces the pattern
//   and restarts the prescaler.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (wins over load and en)
//   en        in   1 = run, 0 = freeze prescaler, pattern and direction
//   mode      in   2'b00 rot-left, 2'b01 rot-right, 2'b10 bounce, 2'b11 hold
//   speed     in   prescaler shift; period P = max(DIV >> speed, 1)
//   load      in   synchronous pattern load strobe (wins over en/step)
//   load_val  in   pattern captured when load = 1
//   led       out  current pattern (registered)
//   dir       out  bounce direction, 0 = left, 1 = right (registered)
//   step      out  one-cycle pulse, high while a freshly stepped led is shown
//
// Configuration macro:
//   LED_ZERO_GUARD_EN - when defined, a step taken while led is all-zero
//                       reloads SEED instead of performing the mode action.
//                       When undefined, an all-zero pattern stays zero.
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int unsigned       WIDTH = 16,
  parameter int unsigned       DIV   = 5000000,
  parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned       CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             step
);

  localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Rotate the pattern one position towards the MSB, MSB wraps to bit 0.
  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Rotate the pattern one position towards the LSB, LSB wraps to the MSB.
  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  // State registers and their next-state values.
  logic [WIDTH-1:0] led_q,  led_d;
  logic             dir_q,  dir_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Prescaler helpers.
  logic [CNT_W-1:0] shifted_s;
  logic [CNT_W-1:0] period_s;
  logic [CNT_W-1:0] last_s;
  logic             fire_s;

  // Pattern/direction that a step would produce this cycle.
  logic [WIDTH-1:0] stepped_led_s;
  logic             stepped_dir_s;

  // Derive the active step period from speed and decide whether a step fires.
  always_comb begin
    shifted_s = DIV_C >> speed;
    // Large shifts can reach zero; the period never drops below one cycle.
    if (shifted_s == ZERO_C) begin
      period_s = ONE_C;
    end else begin
      period_s = shifted_s;
    end
    last_s = period_s - ONE_C;
    // ">=" rather than "==": after speed is raised mid-count the counter may
    // already sit past the new terminal value, and it must fire instead of
    // running all the way round the counter width.
    fire_s = (cnt_q >= last_s);
  end

  // Compute the pattern and direction a step would produce in the current mode.
  always_comb begin
    stepped_led_s = led_q;
    stepped_dir_s = dir_q;
    case (mode)
      MODE_ROTL: begin
        stepped_led_s = rot_left(led_q);
      end
      MODE_ROTR: begin
        stepped_led_s = rot_right(led_q);
      end
      MODE_BOUNCE: begin
        // Turn around on the step that finds the lit end bit, so the end
        // position is shown for exactly one step period.
        if ((dir_q == DIR_LEFT) && led_q[WIDTH-1]) begin
          stepped_dir_s = DIR_RIGHT;
          stepped_led_s = rot_right(led_q);
        end else if ((dir_q == DIR_RIGHT) && led_q[0]) begin
          stepped_dir_s = DIR_LEFT;
          stepped_led_s = rot_left(led_q);
        end else if (dir_q == DIR_RIGHT) begin
          stepped_led_s = rot_right(led_q);
        end else begin
          stepped_led_s = rot_left(led_q);
        end
      end
      MODE_HOLD: begin
        stepped_led_s = led_q;
      end
      default: begin
        stepped_led_s = led_q;
        stepped_dir_s = dir_q;
      end
    endcase
`ifdef LED_ZERO_GUARD_EN
    // A dark bank would otherwise stay dark forever; restart from SEED.
    if (led_q == {WIDTH{1'b0}}) begin
      stepped_led_s = SEED;
      stepped_dir_s = dir_q;
    end else begin
      stepped_led_s = stepped_led_s;
      stepped_dir_s = stepped_dir_s;
    end
`endif
  end

  // Next-state selection: load beats the prescaler, en=0 freezes everything.
  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (load) begin
      // Any step due this cycle is dropped; the new pattern starts a fresh
      // period.
      led_d  = load_val;
      dir_d  = DIR_LEFT;
      cnt_d  = ZERO_C;
      step_d = 1'b0;
    end else if (en) begin
      if (fire_s) begin
        led_d  = stepped_led_s;
        dir_d  = stepped_dir_s;
        cnt_d  = ZERO_C;
        step_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE_C;
        step_d = 1'b0;
      end
    end else begin
      led_d  = led_q;
      dir_d  = dir_q;
      cnt_d  = cnt_q;
      step_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= SEED;
      dir_q  <= DIR_LEFT;
      cnt_q  <= ZERO_C;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern engine for board-level status and demo displays.
- Drives a WIDTH-bit LED bank from a prescaled step tick.
- Runtime-selectable modes: rotate left, rotate right, bounce, hold.
- Runtime speed select, synchronous pattern load, enable/pause, and a step strobe for downstream logic.

Parameters:
WIDTH, 16, LED bank width (>= 2)
DIV, 5000000, base prescaler period in clk cycles (>= 1)
SEED, 1, reset pattern for led (WIDTH bits)
CNT_W, 32, prescaler counter width; must hold DIV-1

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
en  input  1  1 = run; 0 = freeze prescaler and pattern
mode  input  2  00 rot-left, 01 rot-right, 10 bounce, 11 hold
speed  input  2  period P = max(DIV >> speed, 1)
load  input  1  synchronous pattern load strobe
load_val  input  WIDTH  pattern loaded when load=1
led  output  WIDTH  current pattern (registered)
dir  output  1  bounce direction: 0 = left, 1 = right (registered)
step  output  1  one-cycle pulse; high in the cycle a new stepped led value is visible

Behaviour:
- Reset (rst=1 at posedge), held values:
  - led = SEED, dir = 0, step = 0, prescaler cnt = 0.
  - rst overrides load and en.
- Priority per cycle: rst > load > en/step.
- Load (load=1):
  - led <= load_val, cnt <= 0, dir <= 0, step <= 0.
  - Applies regardless of en.
  - A step that would have fired in the same cycle is discarded.
- Prescaler, only when en=1 and no load:
  - If cnt >= P-1: cnt <= 0 and a step fires; otherwise cnt <= cnt+1.
  - The >= compare covers the case where speed is raised mid-count so that cnt already exceeds the new P-1. In that case the step fires on the next cycle; no wrap through 2^CNT_W.
- Step action, registered, so led updates at the edge where the step fires:
  - 00: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
  - 01: led <= {led[0], led[WIDTH-1:1]}.
  - 10 bounce:
    - If dir=0 and led[WIDTH-1]=1: dir <= 1 and rotate right this step.
    - Else if dir=1 and led[0]=1: dir <= 0 and rotate left this step.
    - Else rotate in the current dir.
  - 11: led unchanged; step still pulses.
- step <= 1 exactly when a step fires; otherwise 0.
- en=0: cnt, led and dir hold; step = 0.
  - Re-enabling resumes from the held cnt; no extra step is generated.
- mode and speed are sampled each cycle, so a change takes effect at the next step. The prescaler is not reset by a mode or speed change.
- dir is retained across mode changes. In modes 00, 01 and 11, dir holds its value.
- All-zero pattern is legal and stays zero in every mode unless the optional feature is enabled.
- Latency: load to led = 1 cycle. First step after reset or load fires P cycles later.

Optional Feature:
- Macro: LED_ZERO_GUARD_EN.
- Defined: at a step, if led == 0 then led <= SEED instead of the mode action. dir is unchanged, step pulses.
- Not defined: an all-zero led is held through steps as described above.

Test Plan:
1. WIDTH=8, DIV=4, reset then en=1, mode=00, speed=0 -> led 0x01 becomes 0x02 four cycles later. step pulses every 4 cycles. After 8 steps led = 0x01 again.
2. Mode=01 from 0x01 -> sequence 0x80, 0x40, 0x20; dir stays 0.
3. Mode=10 from 0x01 -> 0x02 … 0x80, then 0x40 with dir=1. Continues down to 0x01, then 0x02 with dir=0.
4. Speed change:
   - speed=2 -> P=1, step pulses every cycle.
   - speed=3 -> P=max(0,1)=1.
   - Switching speed 0->2 with cnt=3 -> step on the next cycle, cnt=0.
5. Load and pause:
   - load=1, load_val=0xA5, in the cycle cnt=P-1 -> led=0xA5, step=0, cnt=0, dir=0.
   - Then en=0 for 10 cycles -> led stays 0xA5, no step.
   - Then rst=1 together with load=1 -> led=SEED.
6. Zero guard: load 0x00 then run one step period -> with LED_ZERO_GUARD_EN led=0x01; without it led=0x00, step still pulses.
